// File: rtl/development_stage_tracker.sv
// -----------------------------------------------------------------------------
// development_stage_tracker
//
// Purpose:
//   Debounces the raw 2-bit development stage into a committed stage. The raw
//   stage is the top bits of a level that can hover on a boundary, so a new
//   value must persist for HOLD_TICKS qualifying ticks before it is committed.
//   Upward movement advances one stage per commit and raises a one-cycle
//   milestone pulse. A downward commit may drop several stages at once and
//   sets a sticky regressed flag.
//
// Optional feature (macro STAGE_TRACKER_LOCK_EN):
//   When defined, every commit enters a LOCK state for LOCK_TICKS ticks,
//   during which raw input changes are ignored.
//
// Ports:
//   clk               in   system clock, rising edge
//   rst               in   synchronous active-high reset
//   tick              in   one-cycle time-base strobe
//   development_stage in   raw stage [1:0]
//   clear_regress     in   clears the sticky regressed flag
//   stage             out  committed, debounced stage [1:0]
//   milestone         out  one-cycle pulse on every upward commit
//   regressed         out  sticky flag, set on any downward commit
//   qualifying        out  high while a candidate stage is being qualified
//   stage_age         out  saturating tick count since the last commit
// -----------------------------------------------------------------------------
module development_stage_tracker #(
  parameter int HOLD_TICKS = 4,
  parameter int AGE_W      = 8,
  parameter int LOCK_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [1:0]       development_stage,
  input  logic             clear_regress,
  output logic [1:0]       stage,
  output logic             milestone,
  output logic             regressed,
  output logic             qualifying,
  output logic [AGE_W-1:0] stage_age
);

  typedef enum logic [1:0] {
    ST_STABLE = 2'd0,
    ST_QUAL   = 2'd1,
    ST_LOCK   = 2'd2
  } state_t;

  localparam logic [3:0]       HOLD_LAST = 4'(HOLD_TICKS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX   = '1;

  // Visible FSM state; checkers may bind to this signal.
  state_t     state;
  logic [1:0] cand;
  logic [3:0] cnt;
  logic [1:0] target;
  logic       commit;

`ifdef STAGE_TRACKER_LOCK_EN
  logic [7:0] lock_cnt;
`else
  logic [7:0] unused_lock_ticks;
  assign unused_lock_ticks = 8'(LOCK_TICKS);
`endif

  // Upward moves are limited to a single step; drops go straight to the raw
  // value. development_stage > stage implies stage < 3, so stage+1 never wraps.
  always_comb begin
    target = development_stage;
    if (development_stage > stage) target = stage + 2'd1;
  end

  // Commit happens on the tick that completes HOLD_TICKS of persistence,
  // provided neither of the higher-priority QUAL rules applies this cycle.
  always_comb begin
    commit = (state == ST_QUAL) && (development_stage != stage) &&
             (target == cand) && tick && (cnt == HOLD_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_STABLE;
      cand       <= 2'd0;
      cnt        <= 4'd0;
      stage      <= 2'd0;
      milestone  <= 1'b0;
      regressed  <= 1'b0;
      qualifying <= 1'b0;
      stage_age  <= '0;
`ifdef STAGE_TRACKER_LOCK_EN
      lock_cnt   <= 8'd0;
`endif
    end else begin
      milestone <= 1'b0;

      // Set beats clear when both land on the same edge.
      if (commit && (cand < stage)) regressed <= 1'b1;
      else if (clear_regress)       regressed <= 1'b0;

      // Commit beats the tick increment.
      if (commit)                              stage_age <= '0;
      else if (tick && (stage_age != AGE_MAX)) stage_age <= stage_age + 1'b1;

      case (state)
        ST_STABLE: begin
          // Entry cycle: tick does not count toward qualification.
          if (development_stage != stage) begin
            cand       <= target;
            cnt        <= 4'd0;
            state      <= ST_QUAL;
            qualifying <= 1'b1;
          end
        end

        ST_QUAL: begin
          if (development_stage == stage) begin
            cnt        <= 4'd0;
            state      <= ST_STABLE;
            qualifying <= 1'b0;
          end else if (target != cand) begin
            cand <= target;
            cnt  <= 4'd0;
          end else if (commit) begin
            stage      <= cand;
            milestone  <= (cand > stage);
            cnt        <= 4'd0;
            qualifying <= 1'b0;
`ifdef STAGE_TRACKER_LOCK_EN
            state      <= ST_LOCK;
            lock_cnt   <= 8'(LOCK_TICKS - 1);
`else
            state      <= ST_STABLE;
`endif
          end else if (tick) begin
            cnt <= cnt + 4'd1;
          end
        end

`ifdef STAGE_TRACKER_LOCK_EN
        ST_LOCK: begin
          // Refractory period: raw input is ignored until the counter expires.
          if (tick) begin
            if (lock_cnt == 8'd0) state    <= ST_STABLE;
            else                  lock_cnt <= lock_cnt - 8'd1;
          end
        end
`endif

        default: begin
          state      <= ST_STABLE;
          qualifying <= 1'b0;
          cnt        <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_development_stage_tracker.sv
// -----------------------------------------------------------------------------
// tb_development_stage_tracker
//
// Purpose:
//   Self-checking bench for development_stage_tracker. Directed phases follow
//   the climb / chatter / jump / regression / age / reset scenarios, then a
//   randomized phase. Every cycle the DUT outputs are compared with a
//   behavioural model that tracks "how many ticks has the candidate persisted".
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_development_stage_tracker;

  localparam int HOLD_TICKS = 4;
  localparam int AGE_W      = 8;
  localparam int LOCK_TICKS = 8;
  localparam int AGE_CAP    = (1 << AGE_W) - 1;

  // ---------------------------------------------------------------- clock/reset
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic [1:0]       development_stage = 2'd0;
  logic             clear_regress = 1'b0;
  logic [1:0]       stage;
  logic             milestone;
  logic             regressed;
  logic             qualifying;
  logic [AGE_W-1:0] stage_age;

  always #5 clk = ~clk;

  development_stage_tracker #(
    .HOLD_TICKS(HOLD_TICKS),
    .AGE_W     (AGE_W),
    .LOCK_TICKS(LOCK_TICKS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .tick             (tick),
    .development_stage(development_stage),
    .clear_regress    (clear_regress),
    .stage            (stage),
    .milestone        (milestone),
    .regressed        (regressed),
    .qualifying       (qualifying),
    .stage_age        (stage_age)
  );

  // ---------------------------------------------------------------- counters
  int n_total = 0;
  int n_pass  = 0;
  int ms_seen = 0;
  logic prev_ms = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // ---------------------------------------------------------------- reference model
  // Stage is committed once a candidate has been seen for the entry cycle plus
  // HOLD_TICKS ticks without interruption.
  int m_stage, m_cand, m_held, m_age, m_lock_left;
  bit m_pending, m_ms, m_reg, m_locked;

  function automatic void model_reset();
    m_stage = 0; m_cand = 0; m_held = 0; m_age = 0; m_lock_left = 0;
    m_pending = 0; m_ms = 0; m_reg = 0; m_locked = 0;
  endfunction

  function automatic void model_step(bit r, bit t, int raw, bit clr);
    int  want;
    bit  do_commit;
    if (r) begin
      model_reset();
      return;
    end
    want = (raw > m_stage) ? m_stage + 1 : raw;
    do_commit = 0;
    m_ms = 0;
    if (m_locked) begin
      if (t) begin
        if (m_lock_left == 0) m_locked = 0;
        else                  m_lock_left--;
      end
    end else if (!m_pending) begin
      if (raw != m_stage) begin
        m_pending = 1; m_cand = want; m_held = 0;
      end
    end else if (raw == m_stage) begin
      m_pending = 0; m_held = 0;
    end else if (want != m_cand) begin
      m_cand = want; m_held = 0;
    end else if (t) begin
      m_held++;
      if (m_held >= HOLD_TICKS) do_commit = 1;
    end

    if (do_commit) begin
      m_ms = (m_cand > m_stage);
      if (m_cand < m_stage) m_reg = 1;
      else if (clr)         m_reg = 0;
      m_stage = m_cand;
      m_pending = 0; m_held = 0; m_age = 0;
`ifdef STAGE_TRACKER_LOCK_EN
      m_locked = 1; m_lock_left = LOCK_TICKS - 1;
`endif
    end else begin
      if (clr) m_reg = 0;
      if (t && m_age < AGE_CAP) m_age++;
    end
  endfunction

  // ---------------------------------------------------------------- driver
  // One clock cycle: drive inputs, step the model on the edge, compare #1 later.
  task automatic cyc(input int raw, input bit t, input bit clr, input bit r = 0);
    development_stage = 2'(raw);
    tick = t;
    clear_regress = clr;
    rst = r;
    @(posedge clk);
    model_step(r, t, raw, clr);
    #1;
    check("stage",      32'(stage),      32'(m_stage));
    check("milestone",  32'(milestone),  32'(m_ms));
    check("regressed",  32'(regressed),  32'(m_reg));
    check("qualifying", 32'(qualifying), 32'(m_pending));
    check("stage_age",  32'(stage_age),  32'(m_age));
    check("ms_not_back_to_back", 32'(prev_ms & milestone), 32'd0);
    prev_ms = milestone;
    if (milestone === 1'b1) ms_seen++;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int raw;
    int ms_start;
    model_reset();

    // Reset for two cycles.
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("reset_stage", 32'(stage), 32'd0);
    check("reset_age",   32'(stage_age), 32'd0);

    // Climb: raw=1, tick every 4th cycle; commit on the 4th tick after entry.
    ms_start = ms_seen;
    for (int i = 0; i < 16; i++) begin
      cyc(1, (i % 4) == 3, 0);
      if (i == 14) check("climb_not_early", 32'(stage), 32'd0);
    end
    check("climb_stage", 32'(stage), 32'd1);
    check("climb_ms", 32'(milestone), 32'd1);
    check("climb_age", 32'(stage_age), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    check("climb_ms_count", 32'(ms_seen - ms_start), 32'd1);

    // Chatter: raw toggles 0/1 every 3 cycles, tick every cycle.
    cyc(0, 0, 0, 1);
    ms_start = ms_seen;
    for (int i = 0; i < 36; i++) cyc(((i / 3) % 2), 1, 0);
    check("chatter_stage", 32'(stage), 32'd0);
    check("chatter_ms_count", 32'(ms_seen - ms_start), 32'd0);

    // Jump: raw 0->3 held, three single-step commits.
    ms_start = ms_seen;
    for (int i = 0; i < 40; i++) cyc(3, 1, 0);
    check("jump_stage", 32'(stage), 32'd3);
    check("jump_ms_count", 32'(ms_seen - ms_start), 32'd3);

    // Regression: drop straight to 0.
    ms_start = ms_seen;
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    check("regress_stage", 32'(stage), 32'd0);
    check("regress_flag", 32'(regressed), 32'd1);
    check("regress_no_ms", 32'(ms_seen - ms_start), 32'd0);

    // Climb to 1, clear the flag, then a downward commit with clear on the same edge.
    for (int i = 0; i < 8; i++) cyc(1, 1, 0);
    cyc(1, 0, 1);
    check("clear_works", 32'(regressed), 32'd0);
    for (int i = 0; i < 8; i++) cyc(0, 1, i == 4);
    check("set_beats_clear", 32'(regressed), 32'd1);

    // Age saturation over 300 ticks on a stable stage.
    for (int i = 0; i < 300; i++) cyc(0, 1, 0);
    check("age_saturated", 32'(stage_age), 32'(AGE_CAP));

    // Reset mid-qualification.
    for (int i = 0; i < 3; i++) cyc(2, 1, 0);
    check("mid_qual", 32'(qualifying), 32'd1);
    cyc(2, 1, 0, 1);
    check("rst_qual", 32'(qualifying), 32'd0);
    check("rst_age", 32'(stage_age), 32'd0);
    check("rst_regressed", 32'(regressed), 32'd0);

    // Randomized phase: raw changes occasionally so commits actually occur.
    raw = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) raw = $urandom_range(0, 3);
      cyc(raw, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
          $urandom_range(0, 499) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
